// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: ISA encodings, redirect
// kinds, the default memory size and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int MEM_BYTES_DEFAULT = 1024;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  typedef enum logic [1:0] {
    RK_BEQ = 2'b00,
    RK_J   = 2'b01,
    RK_JR  = 2'b10,
    RK_JAL = 2'b11
  } redirect_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational control-transfer target computation for the fetch stage.
// All arithmetic is 32-bit and wraps silently; legality is checked elsewhere.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [31:0] if_pc_plus4,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target
);

  logic [31:0] w_branch_off;

  assign w_branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    target = jr_target;
    case (redirect_kind_e'(kind))
      RK_BEQ:        target = if_pc_plus4 + w_branch_off;
      RK_J, RK_JAL:  target = {if_pc_plus4[31:28], jump_index, 2'b00};
      RK_JR:         target = jr_target;
      default:       target = jr_target;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC to an external instruction memory,
// registers the returned word, follows redirects and traps illegal PCs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_pc_plus4;
  logic         r_if_valid;
  logic         r_fault;
  logic [31:0]  r_fault_pc;

  logic         w_pc_illegal;
  logic         w_redirect;
  logic         w_fault;
  logic         w_capture;
  logic [31:0]  w_target;

  assign w_pc_illegal = (r_pc[1:0] != 2'b00) || (r_pc > PC_MAX);

  next_pc_calc u_next_pc_calc (
    .kind        (redirect_kind),
    .if_pc_plus4 (r_if_pc_plus4),
    .branch_imm  (branch_imm),
    .jump_index  (jump_index),
    .jr_target   (jr_target),
    .target      (w_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A redirect outranks the legality check: the current pc is wrong-path and
  // is about to be replaced, so it must not raise a fault.
  always_comb begin
    w_state_nxt = r_state;
    w_redirect  = 1'b0;
    w_fault     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (redirect_valid && r_if_valid) begin
          w_redirect = 1'b1;
        end else if (w_pc_illegal) begin
          w_fault     = 1'b1;
          w_state_nxt = ST_FAULT;
        end else if (!stall) begin
          w_capture = 1'b1;
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
    end else if (w_redirect) begin
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
    end else if (w_fault) begin
      r_fault    <= 1'b1;
      r_fault_pc <= r_pc;
      r_if_valid <= 1'b0;
    end else if (w_capture) begin
      r_if_instr    <= imem_instr;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= r_pc + 32'd4;
      r_if_valid    <= 1'b1;
      r_pc          <= r_pc + 32'd4;
    end
  end

  assign imem_addr   = r_pc;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign if_valid    = r_if_valid;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory whose
// word at byte address a is 32'hA000_0000 + a/4.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_kind  (redirect_kind),
    .branch_imm     (branch_imm),
    .jump_index     (jump_index),
    .jr_target      (jr_target),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .dbg_state      (dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_addr"},  imem_addr,   32'h0);
    check({tag, "_instr"}, if_instr,    32'h0);
    check({tag, "_pc"},    if_pc,       32'h0);
    check({tag, "_pc4"},   if_pc_plus4, 32'h0);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_fault"}, 32'(fault),  32'd0);
    check({tag, "_fpc"},   fault_pc,    32'h0);
  endtask

  task automatic redirect(input logic [1:0] kind, input logic [15:0] imm,
                          input logic [25:0] idx, input logic [31:0] jr);
    redirect_valid = 1'b1;
    redirect_kind  = kind;
    branch_imm     = imm;
    jump_index     = idx;
    jr_target      = jr;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_kind = 2'b00; branch_imm = '0; jump_index = '0; jr_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;

    // IDLE holds without start
    step(); step();
    check("idle_valid", 32'(if_valid), 32'd0);
    check("idle_addr",  imem_addr, 32'h0);

    start = 1'b1; step(); start = 1'b0;
    check("start_state", 32'(dbg_state), 32'd1);
    check("start_addr",  imem_addr, 32'h0);

    // free run: A,B,C at 0,4,8
    step();
    check("run0_instr", if_instr, 32'hA000_0000);
    check("run0_pc",    if_pc,    32'h0);
    check("run0_valid", 32'(if_valid), 32'd1);
    step();
    check("run1_instr", if_instr, 32'hA000_0001);
    check("run1_pc",    if_pc,    32'h4);

    // stall two cycles at if_pc=4
    stall = 1'b1;
    step(); step();
    check("stall_pc",   if_pc,     32'h4);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_instr", if_instr, 32'hA000_0001);
    stall = 1'b0;
    step();
    check("run2_instr", if_instr,    32'hA000_0002);
    check("run2_pc",    if_pc,       32'h8);
    check("run2_pc4",   if_pc_plus4, 32'hC);

    // BEQ at if_pc=8, offset -2 words: 12 - 8 = 4
    redirect(RK_BEQ, 16'hFFFE, 26'h0, 32'h0);
    step();
    redirect_valid = 1'b0;
    check("beq_valid", 32'(if_valid), 32'd0);
    check("beq_addr",  imem_addr, 32'h4);
    check("beq_hold",  if_pc, 32'h8);
    step();
    check("beq_pc",    if_pc,    32'h4);
    check("beq_instr", if_instr, 32'hA000_0001);
    step(); step(); step();
    check("seq_pc10", if_pc, 32'h10);

    // J with stall in the same cycle: redirect wins
    redirect(RK_J, 16'h0, 26'h40, 32'h0);
    stall = 1'b1;
    step();
    stall = 1'b0;
    check("j_addr",  imem_addr, 32'h100);
    check("j_valid", 32'(if_valid), 32'd0);
    // redirect while if_valid=0 is ignored
    redirect(RK_JR, 16'h0, 26'h0, 32'h8);
    step();
    redirect_valid = 1'b0;
    check("ign_pc",    if_pc,       32'h100);
    check("ign_instr", if_instr,    32'hA000_0040);
    check("ign_pc4",   if_pc_plus4, 32'h104);
    check("ign_addr",  imem_addr,   32'h104);

    // JR to misaligned 0x402 -> fault one cycle later
    redirect(RK_JR, 16'h0, 26'h0, 32'h402);
    step();
    redirect_valid = 1'b0;
    check("jr_addr", imem_addr, 32'h402);
    step();
    check("jr_fault", 32'(fault), 32'd1);
    check("jr_fpc",   fault_pc,   32'h402);
    check("jr_valid", 32'(if_valid), 32'd0);
    check("jr_state", 32'(dbg_state), 32'd2);
    start = 1'b1;
    redirect(RK_JR, 16'h0, 26'h0, 32'h0);
    step(); step();
    start = 1'b0; redirect_valid = 1'b0;
    check("sticky_state", 32'(dbg_state), 32'd2);
    check("sticky_addr",  imem_addr, 32'h402);
    check("sticky_fault", 32'(fault), 32'd1);

    // asynchronous reset out of FAULT
    rst_n = 1'b0;
    #1;
    check_reset_values("arst_fault");
    step();
    rst_n = 1'b1;

    // run up to the last legal word and fall off the end
    start = 1'b1; step(); start = 1'b0;
    step();
    check("end0_pc", if_pc, 32'h0);
    redirect(RK_JR, 16'h0, 26'h0, 32'd1012);
    step();
    redirect_valid = 1'b0;
    check("end_addr", imem_addr, 32'd1012);
    step(); step(); step();
    check("end_pc",    if_pc,    32'd1020);
    check("end_instr", if_instr, 32'hA000_00FF);
    check("end_addr2", imem_addr, 32'd1024);
    check("end_nofault", 32'(fault), 32'd0);
    step();
    check("end_fault", 32'(fault),  32'd1);
    check("end_fpc",   fault_pc,    32'd1024);
    check("end_valid", 32'(if_valid), 32'd0);
    check("end_hold",  if_instr,    32'hA000_00FF);

    // asynchronous reset mid-run while stalled
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    check("mid_pc", if_pc, 32'h4);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst_run");
    step();
    stall = 1'b0;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
